// File: rtl/tail_light_pkg.sv
// Shared definitions for the sequential tail-light controller.
//
// Contents:
//   tail_state_t  - controller state encoding. The hazard states exist only
//                   when TAIL_HAZARD_EN is defined.
//   LAMPS_MIN     - smallest supported lamp count per side.
//   STEP_DIV_MIN  - smallest supported prescaler divide ratio.
//   div_width()   - prescaler counter width, $clog2(step_div) floored at 1.
//
// Configuration macro: TAIL_HAZARD_EN (hazard flashing support).
package tail_light_pkg;

  localparam int LAMPS_MIN    = 2;
  localparam int STEP_DIV_MIN = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2
`ifdef TAIL_HAZARD_EN
    ,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
`endif
  } tail_state_t;

  // A divide-by-1 prescaler still needs a one-bit counter to exist.
  function automatic int div_width(input int step_div);
    int w;
    w = $clog2(step_div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tail_light_seq_if.sv
// Request/lamp bundle between the driver-input logic and the lamp drivers.
//
// Parameter:
//   LAMPS        - lamps per side; must match the controller's LAMPS.
// Signals:
//   left, right  - turn requests (level)
//   brake        - brake request (level)
//   hazard       - hazard request (level); ignored unless TAIL_HAZARD_EN
//   left_lamps   - left bank, bit 0 innermost
//   right_lamps  - right bank, bit 0 innermost
//   busy         - controller not idle
// Modports:
//   master - request source / lamp consumer
//   slave  - the controller
interface tail_light_seq_if #(
  parameter int LAMPS = 3
);

  logic             left;
  logic             right;
  logic             brake;
  logic             hazard;
  logic [LAMPS-1:0] left_lamps;
  logic [LAMPS-1:0] right_lamps;
  logic             busy;

  modport master (
    output left, right, brake, hazard,
    input  left_lamps, right_lamps, busy
  );

  modport slave (
    input  left, right, brake, hazard,
    output left_lamps, right_lamps, busy
  );

endinterface

// File: rtl/step_timer.sv
// Step prescaler for the tail-light controller.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   clear  - restart the prescaler at 0 (state entry)
//   tick   - high in the last cycle of each STEP_DIV-cycle step;
//            constantly high when STEP_DIV = 1
// Parameter:
//   STEP_DIV - clock cycles per sequence step
module step_timer #(
  parameter int STEP_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  import tail_light_pkg::*;

  localparam int DIV_EFF = (STEP_DIV < STEP_DIV_MIN) ? STEP_DIV_MIN : STEP_DIV;
  localparam int DIV_W   = div_width(DIV_EFF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_EFF - 1);

  logic [DIV_W-1:0] div_r;

  assign tick = (div_r == DIV_LAST);

  // Prescaler: wraps after the last cycle of a step, restarts on state entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (clear || tick) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/tail_light_seq.sv
// Sequential turn-signal controller for left and right lamp banks.
//
// A turn request fills its bank inner-to-outer, one lamp per step, then the
// bank goes dark for one cycle before a held request restarts it. Left wins
// over right; a request arriving mid-sequence is only seen back in IDLE.
// Brake lights every bank that is not sequencing and reaches the outputs
// combinationally. With TAIL_HAZARD_EN defined, hazard has top priority and
// flashes both banks with equal on/off phases.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset; forces all outputs to 0
//   bus    - tail_light_seq_if.slave (requests in, lamps and busy out)
// Parameters:
//   LAMPS    - lamps per side (>= 2)
//   STEP_DIV - clock cycles per sequence step (>= 1)
// Configuration macro: TAIL_HAZARD_EN.
module tail_light_seq #(
  parameter int LAMPS    = 3,
  parameter int STEP_DIV = 1
) (
  input  logic              clock,
  input  logic              reset,
  tail_light_seq_if.slave   bus
);

  import tail_light_pkg::*;

  localparam int LAMPS_EFF = (LAMPS < LAMPS_MIN) ? LAMPS_MIN : LAMPS;
  localparam int STEP_W    = $clog2(LAMPS_EFF + 1);

  tail_state_t      state_r;
  tail_state_t      state_s;
  logic [STEP_W-1:0] step_r;
  logic [STEP_W-1:0] step_s;
  logic             tick_s;
  logic             clear_s;
  logic [LAMPS-1:0] left_pat_s;
  logic [LAMPS-1:0] right_pat_s;
  logic             busy_s;

`ifndef TAIL_HAZARD_EN
  logic hazard_unused_s;
  assign hazard_unused_s = bus.hazard;
`endif

  // Low `n` bits set: the fill pattern for step n.
  function automatic logic [LAMPS-1:0] fill_mask(input logic [STEP_W-1:0] n);
    logic [LAMPS-1:0] m;
    m = {LAMPS{1'b0}};
    for (int i = 0; i < LAMPS; i++) begin
      if (STEP_W'(i) < n) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Any state change restarts the step prescaler.
  assign clear_s = (state_s != state_r);

  step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clock (clock),
    .reset (reset),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // State and step registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      step_r  <= STEP_W'(1);
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
    end
  end

  // Next-state logic: IDLE arbitrates, turn states run to completion.
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    case (state_r)
      IDLE: begin
        step_s = STEP_W'(1);
`ifdef TAIL_HAZARD_EN
        if (bus.hazard) begin
          state_s = HAZ_ON;
        end else
`endif
        if (bus.left) begin
          state_s = LEFT;
        end else if (bus.right) begin
          state_s = RIGHT;
        end else begin
          state_s = IDLE;
        end
      end
      LEFT, RIGHT: begin
        if (tick_s) begin
          if (step_r == STEP_W'(LAMPS)) begin
            state_s = IDLE;
            step_s  = STEP_W'(1);
          end else begin
            step_s = step_r + STEP_W'(1);
          end
        end else begin
          step_s = step_r;
        end
      end
`ifdef TAIL_HAZARD_EN
      HAZ_ON: begin
        if (tick_s) begin
          state_s = HAZ_OFF;
        end else begin
          state_s = HAZ_ON;
        end
      end
      HAZ_OFF: begin
        if (tick_s) begin
          if (bus.hazard) begin
            state_s = HAZ_ON;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = HAZ_OFF;
        end
      end
`endif
      default: begin
        state_s = IDLE;
        step_s  = STEP_W'(1);
      end
    endcase
  end

  // Lamp decode from state/step, with the brake overlay on idle banks.
  always_comb begin
    left_pat_s  = {LAMPS{1'b0}};
    right_pat_s = {LAMPS{1'b0}};
    case (state_r)
      IDLE: begin
        if (bus.brake) begin
          left_pat_s  = {LAMPS{1'b1}};
          right_pat_s = {LAMPS{1'b1}};
        end else begin
          left_pat_s  = {LAMPS{1'b0}};
          right_pat_s = {LAMPS{1'b0}};
        end
      end
      LEFT: begin
        left_pat_s = fill_mask(step_r);
        if (bus.brake) begin
          right_pat_s = {LAMPS{1'b1}};
        end else begin
          right_pat_s = {LAMPS{1'b0}};
        end
      end
      RIGHT: begin
        right_pat_s = fill_mask(step_r);
        if (bus.brake) begin
          left_pat_s = {LAMPS{1'b1}};
        end else begin
          left_pat_s = {LAMPS{1'b0}};
        end
      end
`ifdef TAIL_HAZARD_EN
      HAZ_ON: begin
        left_pat_s  = {LAMPS{1'b1}};
        right_pat_s = {LAMPS{1'b1}};
      end
      HAZ_OFF: begin
        left_pat_s  = {LAMPS{1'b0}};
        right_pat_s = {LAMPS{1'b0}};
      end
`endif
      default: begin
        left_pat_s  = {LAMPS{1'b0}};
        right_pat_s = {LAMPS{1'b0}};
      end
    endcase
  end

  assign busy_s = (state_r != IDLE);

  // Reset gates the outputs directly so brake cannot light lamps during reset.
  assign bus.left_lamps  = reset ? left_pat_s  : {LAMPS{1'b0}};
  assign bus.right_lamps = reset ? right_pat_s : {LAMPS{1'b0}};
  assign bus.busy        = reset ? busy_s      : 1'b0;

endmodule

// File: tb/tb_tail_light_seq.sv
// Scoreboard bench for tail_light_seq: two instances (3 lamps / divide-by-1
// and 4 lamps / divide-by-2) see the same stimulus. A reference model that
// tracks "activity + elapsed cycles" predicts each cycle's lamps; expectations
// are queued at stimulus time and popped by a negedge monitor.
module tb_tail_light_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef TAIL_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  tail_light_seq_if #(.LAMPS(3)) bus0 ();
  tail_light_seq_if #(.LAMPS(4)) bus1 ();

  tail_light_seq #(.LAMPS(3), .STEP_DIV(1)) dut0 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus0.slave)
  );

  tail_light_seq #(.LAMPS(4), .STEP_DIV(2)) dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus1.slave)
  );

  // Model: mode 0 idle, 1 left, 2 right, 3 hazard; el = cycles into activity.
  int m_mode [2];
  int m_el   [2];
  bit cur_l, cur_r, cur_b, cur_h, cur_rst;

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int checks = 0;
  int passed = 0;

  function automatic int lamps_of(input int i);
    return (i == 0) ? 3 : 4;
  endfunction

  function automatic int sd_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  // Advance one clock edge using the inputs that were stable across it.
  task automatic model_step(input int i);
    if (!cur_rst) begin
      m_mode[i] = 0;
      m_el[i]   = 0;
    end else begin
      case (m_mode[i])
        0: begin
          m_el[i] = 0;
          if (HAZ_EN && cur_h)  m_mode[i] = 3;
          else if (cur_l)       m_mode[i] = 1;
          else if (cur_r)       m_mode[i] = 2;
        end
        1, 2: begin
          m_el[i]++;
          if (m_el[i] == lamps_of(i) * sd_of(i)) m_mode[i] = 0;
        end
        3: begin
          m_el[i]++;
          if (m_el[i] == 2 * sd_of(i)) begin
            if (cur_h) m_el[i] = 0;
            else       m_mode[i] = 0;
          end
        end
        default: m_mode[i] = 0;
      endcase
    end
  endtask

  // Expected {busy, left[3:0], right[3:0]} for the current cycle.
  function automatic logic [8:0] expect_out(input int i);
    logic [3:0] all_on, l, r;
    logic       busy;
    int         sd;
    sd     = sd_of(i);
    all_on = 4'((1 << lamps_of(i)) - 1);
    l = 4'd0;
    r = 4'd0;
    busy = 1'b0;
    if (cur_rst) begin
      busy = (m_mode[i] != 0);
      case (m_mode[i])
        0: if (cur_b) begin l = all_on; r = all_on; end
        1: begin l = 4'((1 << (m_el[i] / sd + 1)) - 1); if (cur_b) r = all_on; end
        2: begin r = 4'((1 << (m_el[i] / sd + 1)) - 1); if (cur_b) l = all_on; end
        3: if (m_el[i] < sd) begin l = all_on; r = all_on; end
        default: ;
      endcase
    end
    return {busy, l, r};
  endfunction

  // One cycle: advance the model over the edge, apply new inputs, queue expectations.
  task automatic cyc(input bit l, input bit r, input bit b, input bit h, input bit rs = 1'b1);
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    cur_l = l; cur_r = r; cur_b = b; cur_h = h; cur_rst = rs;
    bus0.left = l; bus0.right = r; bus0.brake = b; bus0.hazard = h;
    bus1.left = l; bus1.right = r; bus1.brake = b; bus1.hazard = h;
    rst_n = rs;
    q0.push_back(expect_out(0));
    q1.push_back(expect_out(1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [8:0] act0, exp0, act1, exp1;

  // Monitor: compare each instance's outputs against the queued expectation.
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      exp0 = q0.pop_front();
      act0 = {bus0.busy, 1'b0, bus0.left_lamps, 1'b0, bus0.right_lamps};
      checks++;
      if (act0 === exp0) passed++;
      else $display("FAIL dut0 t=%0t: got busy=%b L=%b R=%b, expected busy=%b L=%b R=%b",
                    $time, act0[8], act0[7:4], act0[3:0], exp0[8], exp0[7:4], exp0[3:0]);
    end
    if (q1.size() > 0) begin
      exp1 = q1.pop_front();
      act1 = {bus1.busy, bus1.left_lamps, bus1.right_lamps};
      checks++;
      if (act1 === exp1) passed++;
      else $display("FAIL dut1 t=%0t: got busy=%b L=%b R=%b, expected busy=%b L=%b R=%b",
                    $time, act1[8], act1[7:4], act1[3:0], exp1[8], exp1[7:4], exp1[3:0]);
    end
  end

  initial begin
    cur_l = 1'b0; cur_r = 1'b0; cur_b = 1'b0; cur_h = 1'b0; cur_rst = 1'b0;
    rst_n = 1'b0;
    bus0.left = 1'b0; bus0.right = 1'b0; bus0.brake = 1'b0; bus0.hazard = 1'b0;
    bus1.left = 1'b0; bus1.right = 1'b0; bus1.brake = 1'b0; bus1.hazard = 1'b0;

    // Reset held with brake and requests high: outputs must stay dark.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Single-cycle left pulse.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);

    // Left and right held together: left wins, repeats.
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(9);

    // Right pulse, then left held from the next cycle.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);

    // Right held with brake on.
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle(9);

    // Reset dropped mid-sequence, then a fresh right request.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(9);

    // Hazard with left held, then hazard released (ignored without the macro).
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 49) != 0));
    end
    idle(4);

    repeat (2) @(posedge clk);
    checks++;
    if (q0.size() == 0 && q1.size() == 0) passed++;
    else $display("FAIL drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tail_light_seq.md
# tail_light_seq

Parametrised sequential turn-signal controller for left and right lamp banks. Each bank has `LAMPS` lamps. A turn request runs an inner-to-outer fill sequence at a programmable step rate, with left-over-right priority and brake overlay. Hazard flashing is optional. The block drives the lamp outputs directly and sits between the driver-input debounce logic and the lamp drivers.

## Interface
- `LAMPS`, default 3: lamps per side, ≥2.
- `STEP_DIV`, default 1: clock cycles per sequence step, ≥1.
- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low; 0 = reset.
- `left` input 1: left turn request, level.
- `right` input 1: right turn request, level.
- `brake` input 1: brake request, level.
- `hazard` input 1: hazard request, level. Ignored unless `TAIL_HAZARD_EN` is defined.
- `left_lamps` output `LAMPS`: bit 0 is the innermost lamp, bit `LAMPS-1` the outermost.
- `right_lamps` output `LAMPS`: bit 0 is the innermost lamp.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF.
- Step counter `step` covers 1..`LAMPS`. Prescaler `div` covers 0..`STEP_DIV-1`.
- `tick` is asserted when `div == STEP_DIV-1`. `div` is cleared on every state entry.
- IDLE:
  - Requests are sampled every clock; priority is hazard > left > right.
  - Left → LEFT with step=1. Right → RIGHT with step=1. Hazard → HAZ_ON.
  - No request: stay in IDLE.
- LEFT/RIGHT:
  - On `tick`, step increments.
  - On `tick` with step=`LAMPS`, return to IDLE.
  - All inputs other than reset are ignored until the return to IDLE.
- HAZ_ON → HAZ_OFF on `tick`.
- HAZ_OFF on `tick`:
  - Hazard still high → HAZ_ON.
  - Hazard low → IDLE.
- Lamp decode (Moore, from state and step only):
  - LEFT: `left_lamps` = low `step` bits set, i.e. `(1<<step)-1`.
  - RIGHT: same pattern on `right_lamps`.
  - HAZ_ON: both banks all ones.
  - HAZ_OFF and IDLE: zero.
- Brake overlay:
  - When `brake`=1 and the state is not HAZ_ON/HAZ_OFF, every bank not currently sequencing reads all ones.
  - In IDLE with `brake`=1, both banks read all ones.
  - In hazard states, the hazard pattern wins over brake.
- A held turn request restarts the sequence from IDLE. IDLE (all dark on that side) lasts exactly one cycle between sequences.
- A request for the opposite side during a sequence takes effect only after the return to IDLE, and only if it is still held.

## Timing
- Reset:
  - All outputs are 0 immediately, asynchronously.
  - State becomes IDLE, step becomes 1, div becomes 0.
  - Deassertion is sampled at the next rising edge.
- Latency: a request high at edge N produces the first lamp pattern after edge N.
- Each step lasts exactly `STEP_DIV` cycles.
- Full sequence: `LAMPS·STEP_DIV` cycles plus 1 IDLE cycle. With defaults this is a 4-cycle period while the request is held.
- Hazard: on and off phases are `STEP_DIV` cycles each.
- `brake` is combinational into the outputs, with zero-cycle effect. It is the only input that reaches the outputs combinationally.
- Reset mid-sequence or mid-hazard: the sequence is abandoned. No resume.

## Configuration
- `TAIL_HAZARD_EN` defined: the HAZ_ON/HAZ_OFF states and the hazard priority exist.
- Not defined:
  - The `hazard` port remains but is ignored.
  - The hazard states are not generated.
  - IDLE priority is left > right.

## Structure
- Shared package `tail_light_pkg`:
  - state enum `tail_state_t`;
  - localparams for minimum `LAMPS`/`STEP_DIV`;
  - prescaler width function, `$clog2(STEP_DIV)` floored at 1.
- Sub-module `step_timer`:
  - Owns the prescaler.
  - Inputs: `clock`, `reset`, `clear`.
  - Output: `tick`.
  - Parameter: `STEP_DIV`.
  - Asserts `tick` every cycle when `STEP_DIV`=1.

## Test plan
- Defaults, `left` pulsed for 1 cycle after reset: `left_lamps` must read 001, 011, 111, 000 on consecutive cycles; `right_lamps` stays 000; `busy` stays high for 3 cycles.
- Defaults, `left` and `right` both held for 8 cycles: only the left sequence runs, twice (001, 011, 111, 000 repeated); `right_lamps` stays 000.
- Defaults, `right` pulsed then `left` held from the next cycle: right runs 001, 011, 111 unaffected, then IDLE for 1 cycle, then the left sequence starts.
- `LAMPS`=4, `STEP_DIV`=2, `right` held:
  - `right_lamps` reads 0001×2, 0011×2, 0111×2, 1111×2, 0000×1 cycles, then repeats.
  - `brake`=1 forces `left_lamps`=1111 throughout.
- Defaults, `reset` driven low asynchronously in the middle of the 011 step, then released: outputs go to 0 before the next edge; a new `right` request then starts at 001.
- With `TAIL_HAZARD_EN` defined, `STEP_DIV`=2, `hazard` and `left` held together:
  - Both banks read 111 for 2 cycles, then 000 for 2 cycles, repeating.
  - Releasing `hazard` during HAZ_ON: the current flash period finishes, then IDLE, then the left sequence starts.
